// File: rtl/sha2_round_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sha2_round_engine
//
// SHA-2 compression core. It takes an 8-word chaining value, runs the
// working-variable round function over a whole block (64 rounds for 32-bit
// words, 80 rounds for 64-bit words), then adds the saved chaining value back
// in (feed-forward) to produce the updated chaining value.
//
// UNROLL rounds are evaluated per clock, so a block spends
// NROUNDS/UNROLL cycles in ROUND, then one cycle in FEED, then waits in OUT
// until the digest is taken. Per-round K and W words are fetched through an
// indexed port: the engine presents round_idx and expects lane j of
// k_in/w_in to hold the word for round round_idx+j in the same cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   chaining value on h_in is valid
//   in_ready   engine accepts a block this cycle
//   h_in       chaining value, word a in the low WORD_W bits, h in the top
//   abort      cancel the block in flight (ignored when idle)
//   round_idx  first round evaluated this cycle (0 outside ROUND)
//   k_in       UNROLL K words, lane j = K[round_idx+j]
//   w_in       UNROLL W words, lane j = W[round_idx+j]
//   busy       high while rounds or feed-forward are running
//   out_valid  h_out holds a finished digest
//   out_ready  consumer takes the digest
//   h_out      updated chaining value, same packing as h_in
// -----------------------------------------------------------------------------
module sha2_round_engine #(
  parameter int WORD_W = 32,  // 32: SHA-224/256, 64: SHA-384/512/512_t
  parameter int UNROLL = 1    // rounds per clock: 1, 2, 4 or 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*WORD_W-1:0]        h_in,
  input  logic                       abort,
  output logic [6:0]                 round_idx,
  input  logic [UNROLL*WORD_W-1:0]   k_in,
  input  logic [UNROLL*WORD_W-1:0]   w_in,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*WORD_W-1:0]        h_out
);

  localparam int NROUNDS = (WORD_W == 32) ? 64 : 80;

  // Round counter value during the final ROUND cycle, and its increment.
  localparam logic [6:0] LAST_IDX = 7'(NROUNDS - UNROLL);
  localparam logic [6:0] STEP     = 7'(UNROLL);

  // Big-sigma rotation amounts.
  localparam int S0_R0 = (WORD_W == 32) ? 2  : 28;
  localparam int S0_R1 = (WORD_W == 32) ? 13 : 34;
  localparam int S0_R2 = (WORD_W == 32) ? 22 : 39;
  localparam int S1_R0 = (WORD_W == 32) ? 6  : 14;
  localparam int S1_R1 = (WORD_W == 32) ? 11 : 18;
  localparam int S1_R2 = (WORD_W == 32) ? 25 : 41;

  typedef logic [WORD_W-1:0] word_t;
  // Element 0 is working variable a, element 7 is h; the packed layout
  // matches the h_in/h_out bus so the buses cast directly.
  typedef word_t [7:0] wvec_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_FEED,
    S_OUT
  } state_e;

  state_e     state_q, state_d;
  wvec_t      work_q,  work_d;   // working variables a..h
  wvec_t      h0_q,    h0_d;     // chaining value saved for feed-forward
  wvec_t      hout_q,  hout_d;   // registered digest
  logic [6:0] cnt_q,   cnt_d;    // index of the next round to evaluate
  wvec_t      round_out;

  function automatic word_t rotr(word_t x, int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic wvec_t sha2_round(wvec_t s, word_t k, word_t w);
    word_t big_s0, big_s1, ch, maj, t1, t2;
    wvec_t r;
    big_s1 = rotr(s[4], S1_R0) ^ rotr(s[4], S1_R1) ^ rotr(s[4], S1_R2);
    big_s0 = rotr(s[0], S0_R0) ^ rotr(s[0], S0_R1) ^ rotr(s[0], S0_R2);
    ch     = (s[4] & s[5]) ^ (~s[4] & s[6]);
    maj    = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    t1     = s[7] + big_s1 + ch + k + w;
    t2     = big_s0 + maj;
    r[0]   = t1 + t2;
    r[1]   = s[0];
    r[2]   = s[1];
    r[3]   = s[2];
    r[4]   = s[3] + t1;
    r[5]   = s[4];
    r[6]   = s[5];
    r[7]   = s[6];
    return r;
  endfunction

  // UNROLL rounds chained back to back; this chain is the critical path.
  always_comb begin : round_chain
    round_out = work_q;
    for (int j = 0; j < UNROLL; j++) begin
      round_out = sha2_round(round_out, k_in[j*WORD_W +: WORD_W],
                             w_in[j*WORD_W +: WORD_W]);
    end
  end

  // Next-state logic. Abort outranks every other request once a block has
  // been accepted; in IDLE it has nothing to cancel and is ignored.
  always_comb begin : next_state
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    work_d  = work_q;
    h0_d    = h0_q;
    hout_d  = hout_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = wvec_t'(h_in);
          h0_d    = wvec_t'(h_in);
          cnt_d   = '0;
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          work_d = round_out;
          cnt_d  = cnt_q + STEP;
          if (cnt_q == LAST_IDX) state_d = S_FEED;
        end
      end

      S_FEED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          for (int i = 0; i < 8; i++) hout_d[i] = h0_q[i] + work_q[i];
          state_d = S_OUT;
        end
      end

      S_OUT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (in_valid) begin
            // Digest handed off and the next block loaded in the same cycle.
            work_d  = wvec_t'(h_in);
            h0_d    = wvec_t'(h_in);
            cnt_d   = '0;
            state_d = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state only (plus the OUT-state
  // pass-through of out_ready).
  always_comb begin : outputs
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    round_idx = '0;
    unique case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_ROUND: begin
        busy      = 1'b1;
        round_idx = cnt_q;
      end
      S_FEED:  busy = 1'b1;
      // An aborting cycle cannot take a new block, so do not advertise it.
      S_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~abort;
      end
      default: ;
    endcase
  end

  assign h_out = hout_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, not just the FSM, because
      // h_out is architecturally visible and must read zero out of reset.
      state_q <= S_IDLE;
      work_q  <= '0;
      h0_q    <= '0;
      hout_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      h0_q    <= h0_d;
      hout_q  <= hout_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sha2_round_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sha2_round_engine
//
// Three engines side by side: 32-bit/UNROLL=1, 64-bit/UNROLL=2 and
// 32-bit/UNROLL=4. The bench feeds K from the standard SHA-512 constant table
// (SHA-256 K is its upper half) and W from a message schedule it expands
// itself. Expected digests are either published "abc" answers or come from a
// straightforward round-by-round compression model.
// -----------------------------------------------------------------------------
module tb_sha2_round_engine;

  localparam int NI = 3;

  typedef logic [7:0][63:0]  vec8_t;   // element 0 = word a
  typedef logic [79:0][63:0] sched_t;  // element t = W[t]

  typedef struct {
    int    inst;
    vec8_t iv;
    sched_t wt;
    vec8_t exp;
  } vec_t;

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Chaining values and digests, listed h..a so that element 0 is word a.
  localparam vec8_t IV256 = {64'h5be0cd19, 64'h1f83d9ab, 64'h9b05688c, 64'h510e527f,
                             64'ha54ff53a, 64'h3c6ef372, 64'hbb67ae85, 64'h6a09e667};
  localparam vec8_t ABC256 = {64'hf20015ad, 64'hb410ff61, 64'h96177a9c, 64'hb00361a3,
                              64'h5dae2223, 64'h414140de, 64'h8f01cfea, 64'hba7816bf};
  localparam vec8_t IV512 = {64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
                             64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
                             64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
                             64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};
  localparam vec8_t ABC512 = {64'h2a9ac94fa54ca49f, 64'h454d4423643ce80e,
                              64'h36ba3c23a3feebbd, 64'h2192992a274fc1a8,
                              64'h0a9eeee64b55d39a, 64'h12e6fa4e89a97ea2,
                              64'hcc417349ae204131, 64'hddaf35a193617aba};

  logic clk;
  logic         rst_s       [NI];
  logic         in_valid_s  [NI];
  logic         abort_s     [NI];
  logic         out_ready_s [NI];
  logic [511:0] h_in_s      [NI];
  logic         in_ready_w  [NI];
  logic         busy_w      [NI];
  logic         out_valid_w [NI];
  logic [6:0]   ridx_w      [NI];
  logic [511:0] h_out_w     [NI];
  sched_t       wtab        [NI];

  int n_vec = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 0: 32-bit, UNROLL=1 ----------------
  logic [255:0] ho0;
  logic [31:0]  k0, w0;
  logic         ir0, bz0, ov0;
  logic [6:0]   ri0;
  sha2_round_engine #(.WORD_W(32), .UNROLL(1)) u0 (
    .clk(clk), .rst(rst_s[0]), .in_valid(in_valid_s[0]), .in_ready(ir0),
    .h_in(h_in_s[0][255:0]), .abort(abort_s[0]), .round_idx(ri0),
    .k_in(k0), .w_in(w0), .busy(bz0), .out_valid(ov0),
    .out_ready(out_ready_s[0]), .h_out(ho0));
  assign in_ready_w[0] = ir0;
  assign busy_w[0] = bz0;
  assign out_valid_w[0] = ov0;
  assign ridx_w[0] = ri0;
  assign h_out_w[0] = {256'b0, ho0};
  always_comb begin
    k0 = '0;
    w0 = '0;
    if (int'(ri0) < 80) begin
      k0 = K512[int'(ri0)][63:32];
      w0 = wtab[0][int'(ri0)][31:0];
    end
  end

  // ---------------- DUT 1: 64-bit, UNROLL=2 ----------------
  logic [511:0] ho1;
  logic [127:0] k1, w1;
  logic         ir1, bz1, ov1;
  logic [6:0]   ri1;
  sha2_round_engine #(.WORD_W(64), .UNROLL(2)) u1 (
    .clk(clk), .rst(rst_s[1]), .in_valid(in_valid_s[1]), .in_ready(ir1),
    .h_in(h_in_s[1]), .abort(abort_s[1]), .round_idx(ri1),
    .k_in(k1), .w_in(w1), .busy(bz1), .out_valid(ov1),
    .out_ready(out_ready_s[1]), .h_out(ho1));
  assign in_ready_w[1] = ir1;
  assign busy_w[1] = bz1;
  assign out_valid_w[1] = ov1;
  assign ridx_w[1] = ri1;
  assign h_out_w[1] = ho1;
  always_comb begin
    k1 = '0;
    w1 = '0;
    for (int j = 0; j < 2; j++) begin
      if (int'(ri1) + j < 80) begin
        k1[j*64 +: 64] = K512[int'(ri1) + j];
        w1[j*64 +: 64] = wtab[1][int'(ri1) + j];
      end
    end
  end

  // ---------------- DUT 2: 32-bit, UNROLL=4 ----------------
  logic [255:0] ho2;
  logic [127:0] k2, w2;
  logic         ir2, bz2, ov2;
  logic [6:0]   ri2;
  sha2_round_engine #(.WORD_W(32), .UNROLL(4)) u2 (
    .clk(clk), .rst(rst_s[2]), .in_valid(in_valid_s[2]), .in_ready(ir2),
    .h_in(h_in_s[2][255:0]), .abort(abort_s[2]), .round_idx(ri2),
    .k_in(k2), .w_in(w2), .busy(bz2), .out_valid(ov2),
    .out_ready(out_ready_s[2]), .h_out(ho2));
  assign in_ready_w[2] = ir2;
  assign busy_w[2] = bz2;
  assign out_valid_w[2] = ov2;
  assign ridx_w[2] = ri2;
  assign h_out_w[2] = {256'b0, ho2};
  always_comb begin
    k2 = '0;
    w2 = '0;
    for (int j = 0; j < 4; j++) begin
      if (int'(ri2) + j < 80) begin
        k2[j*32 +: 32] = K512[int'(ri2) + j][63:32];
        w2[j*32 +: 32] = wtab[2][int'(ri2) + j][31:0];
      end
    end
  end

  // ---------------- configuration helpers ----------------
  function automatic int ww_of(int inst);
    return (inst == 1) ? 64 : 32;
  endfunction
  function automatic int unroll_of(int inst);
    return (inst == 0) ? 1 : (inst == 1) ? 2 : 4;
  endfunction
  function automatic int ncyc_of(int inst);
    return ((ww_of(inst) == 32) ? 64 : 80) / unroll_of(inst);
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [63:0] msk(int w);
    return (w == 32) ? 64'h0000_0000_ffff_ffff : '1;
  endfunction
  function automatic logic [63:0] rotr(logic [63:0] x, int n, int w);
    return ((x >> n) | (x << (w - n))) & msk(w);
  endfunction
  function automatic logic [63:0] bs0(logic [63:0] x, int w);
    return (w == 32) ? rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w)
                     : rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w);
  endfunction
  function automatic logic [63:0] bs1(logic [63:0] x, int w);
    return (w == 32) ? rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w)
                     : rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w);
  endfunction
  function automatic logic [63:0] ss0(logic [63:0] x, int w);
    return (w == 32) ? rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3)
                     : rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] ss1(logic [63:0] x, int w);
    return (w == 32) ? rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10)
                     : rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  function automatic sched_t expand(int w, logic [15:0][63:0] m);
    sched_t s;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) s[t] = m[t] & msk(w);
      else s[t] = (ss1(s[t-2], w) + s[t-7] + ss0(s[t-15], w) + s[t-16]) & msk(w);
    end
    return s;
  endfunction

  function automatic sched_t abc_sched(int w);
    logic [15:0][63:0] m;
    m = '0;
    m[0]  = (w == 32) ? 64'h61626380 : 64'h6162638000000000;
    m[15] = 64'h18;
    return expand(w, m);
  endfunction

  function automatic vec8_t ref_compress(int w, vec8_t iv, sched_t wt);
    vec8_t v, r;
    logic [63:0] kt, t1, t2, ch, maj;
    int nr;
    nr = (w == 32) ? 64 : 80;
    v = iv;
    for (int t = 0; t < nr; t++) begin
      kt  = (w == 32) ? (K512[t] >> 32) : K512[t];
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1  = (v[7] + bs1(v[4], w) + ch + kt + wt[t]) & msk(w);
      t2  = (bs0(v[0], w) + maj) & msk(w);
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = (v[4] + t1) & msk(w);
      v[0] = (t1 + t2) & msk(w);
    end
    for (int i = 0; i < 8; i++) r[i] = (iv[i] + v[i]) & msk(w);
    return r;
  endfunction

  function automatic logic [511:0] pack8(int w, vec8_t v);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (w == 32) r[i*32 +: 32] = v[i][31:0];
      else r[i*64 +: 64] = v[i];
    end
    return r;
  endfunction

  function automatic vec8_t rand_vec8(int w);
    vec8_t v;
    for (int i = 0; i < 8; i++) v[i] = {$urandom, $urandom} & msk(w);
    return v;
  endfunction

  function automatic sched_t rand_sched(int w);
    logic [15:0][63:0] m;
    for (int i = 0; i < 16; i++) m[i] = {$urandom, $urandom};
    return expand(w, m);
  endfunction

  // ---------------- checking and driving ----------------
  task automatic check(input string name, input logic [511:0] got,
                       input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Presents a block and returns just after the accepting clock edge.
  task automatic start_block(input int inst, input vec8_t iv, input sched_t wt,
                             input bit hold);
    @(negedge clk);
    wtab[inst]       = wt;
    h_in_s[inst]     = pack8(ww_of(inst), iv);
    in_valid_s[inst] = 1'b1;
    check($sformatf("u%0d_ready_at_accept", inst), 512'(in_ready_w[inst]), 512'd1);
    @(posedge clk);
    #1;
    if (!hold) in_valid_s[inst] = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid, tracing round_idx.
  task automatic wait_out(input int inst, output int lat, output bit idx_ok);
    int nc, u;
    nc = ncyc_of(inst);
    u  = unroll_of(inst);
    lat = -1;
    idx_ok = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (out_valid_w[inst]) begin
        lat = n;
        break;
      end
      if (n <= nc) begin
        if (!(busy_w[inst] && int'(ridx_w[inst]) == (n - 1) * u)) idx_ok = 1'b0;
      end else if (n == nc + 1) begin
        if (!(busy_w[inst] && ridx_w[inst] == 7'd0)) idx_ok = 1'b0;
      end
    end
    if (lat < 0) $display("FAIL u%0d_timeout: got no out_valid, expected one within 300 cycles", inst);
  endtask

  task automatic run_and_check(input string tag, input int inst, input vec8_t iv,
                               input sched_t wt, input vec8_t exp);
    int lat;
    bit ok;
    out_ready_s[inst] = 1'b1;
    start_block(inst, iv, wt, 1'b0);
    wait_out(inst, lat, ok);
    check({tag, "_latency"}, 512'(lat), 512'(ncyc_of(inst) + 2));
    check({tag, "_round_idx_seq"}, 512'(ok), 512'd1);
    check({tag, "_digest"}, h_out_w[inst], pack8(ww_of(inst), exp));
    @(negedge clk);
    check({tag, "_valid_drops"}, 512'(out_valid_w[inst]), 512'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    vec_t  vecs[12];
    vec8_t first, b_exp, iv;
    sched_t wt;
    int    lat;
    bit    ok, found;

    for (int i = 0; i < NI; i++) begin
      rst_s[i] = 1'b1;
      in_valid_s[i] = 1'b0;
      abort_s[i] = 1'b0;
      out_ready_s[i] = 1'b0;
      h_in_s[i] = '0;
      wtab[i] = '0;
    end

    // Vector table: published "abc" answers, then random blocks whose
    // expectation comes from the compression model.
    vecs[0] = '{inst: 0, iv: IV256, wt: abc_sched(32), exp: ABC256};
    vecs[1] = '{inst: 1, iv: IV512, wt: abc_sched(64), exp: ABC512};
    vecs[2] = '{inst: 2, iv: IV256, wt: abc_sched(32), exp: ABC256};
    for (int i = 3; i < 12; i++) begin
      vecs[i].inst = (i - 3) % NI;
      vecs[i].iv   = rand_vec8(ww_of(vecs[i].inst));
      vecs[i].wt   = rand_sched(ww_of(vecs[i].inst));
      vecs[i].exp  = ref_compress(ww_of(vecs[i].inst), vecs[i].iv, vecs[i].wt);
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;

    // Reset state.
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d_rst_in_ready", i), 512'(in_ready_w[i]), 512'd1);
      check($sformatf("u%0d_rst_busy", i), 512'(busy_w[i]), 512'd0);
      check($sformatf("u%0d_rst_out_valid", i), 512'(out_valid_w[i]), 512'd0);
      check($sformatf("u%0d_rst_round_idx", i), 512'(ridx_w[i]), 512'd0);
      check($sformatf("u%0d_rst_h_out", i), h_out_w[i], 512'd0);
    end

    for (int i = 0; i < 12; i++)
      run_and_check($sformatf("vec%0d_u%0d", i, vecs[i].inst), vecs[i].inst,
                    vecs[i].iv, vecs[i].wt, vecs[i].exp);

    // Back-to-back on the UNROLL=4 engine: second block chains from the first.
    b_exp = ref_compress(32, ABC256, abc_sched(32));
    out_ready_s[2] = 1'b1;
    start_block(2, IV256, abc_sched(32), 1'b1);
    h_in_s[2] = pack8(32, ABC256);
    wait_out(2, lat, ok);
    check("b2b_first_latency", 512'(lat), 512'd18);
    check("b2b_first_digest", h_out_w[2], pack8(32, ABC256));
    check("b2b_in_ready_at_handshake", 512'(in_ready_w[2]), 512'd1);
    @(posedge clk);
    #1;
    in_valid_s[2] = 1'b0;
    wait_out(2, lat, ok);
    check("b2b_second_latency", 512'(lat), 512'd18);
    check("b2b_second_round_idx_seq", 512'(ok), 512'd1);
    check("b2b_second_digest", h_out_w[2], pack8(32, b_exp));
    @(negedge clk);

    // Backpressure on engine 0.
    iv = rand_vec8(32);
    wt = rand_sched(32);
    out_ready_s[0] = 1'b0;
    start_block(0, iv, wt, 1'b0);
    wait_out(0, lat, ok);
    check("bp_latency", 512'(lat), 512'd66);
    first = '0;
    for (int i = 0; i < 8; i++) first[i] = 64'(h_out_w[0][i*32 +: 32]);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_h_out", c), h_out_w[0], pack8(32, first));
      check($sformatf("bp_hold%0d_ready_valid", c),
            512'({in_ready_w[0], out_valid_w[0]}), 512'b01);
    end
    check("bp_digest", h_out_w[0], pack8(32, ref_compress(32, iv, wt)));
    out_ready_s[0] = 1'b1;
    #1;
    check("bp_in_ready_follows", 512'(in_ready_w[0]), 512'd1);
    @(negedge clk);
    check("bp_consumed", 512'(out_valid_w[0]), 512'd0);

    // Abort at round_idx 10 with a competing in_valid.
    start_block(0, IV256, abc_sched(32), 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ridx_w[0] == 7'd10) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_idx10", 512'(found), 512'd1);
    abort_s[0] = 1'b1;
    in_valid_s[0] = 1'b1;
    @(negedge clk);
    check("abort_next_state",
          512'({busy_w[0], out_valid_w[0], in_ready_w[0], ridx_w[0]}),
          512'({1'b0, 1'b0, 1'b1, 7'd0}));
    abort_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    ok = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (out_valid_w[0] || busy_w[0]) ok = 1'b0;
    end
    check("abort_no_digest", 512'(ok), 512'd1);
    run_and_check("after_abort", 0, IV256, abc_sched(32), ABC256);

    // Abort while idle is ignored; the simultaneous block is accepted.
    @(negedge clk);
    wtab[1] = abc_sched(64);
    h_in_s[1] = pack8(64, IV512);
    abort_s[1] = 1'b1;
    in_valid_s[1] = 1'b1;
    @(negedge clk);
    in_valid_s[1] = 1'b0;
    check("idle_abort_accepted", 512'({busy_w[1], ridx_w[1]}), 512'({1'b1, 7'd0}));
    @(negedge clk);
    abort_s[1] = 1'b0;
    check("round_abort_busy", 512'(busy_w[1]), 512'd0);

    // Synchronous reset during FEED.
    start_block(0, IV256, abc_sched(32), 1'b0);
    for (int n = 1; n <= 65; n++) @(negedge clk);
    check("feed_state", 512'({busy_w[0], out_valid_w[0], ridx_w[0]}),
          512'({1'b1, 1'b0, 7'd0}));
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0;
    check("rst_feed_h_out", h_out_w[0], 512'd0);
    check("rst_feed_status", 512'({in_ready_w[0], busy_w[0], out_valid_w[0]}),
          512'b100);
    ok = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (out_valid_w[0]) ok = 1'b0;
    end
    check("rst_feed_no_digest", 512'(ok), 512'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sha2_round_engine.md
# sha2_round_engine

Parametrised SHA-2 compression engine that iterates the working-variable round function over a full block and applies the final feed-forward addition. It sits after the message-schedule stage and before the digest/truncation logic. One block runs from an 8-word chaining value to an 8-word updated chaining value. Rounds per cycle and word width are configurable, and per-round K/W words are fetched through an indexed port.

## Interface
- WORD_W, 32: word width; 32 selects SHA-224/256 (64 rounds), 64 selects SHA-384/512/512_t (80 rounds).
- UNROLL, 1: rounds computed per clock; legal values 1, 2, 4, 8.
- Derived constant: NROUNDS = 64 when WORD_W==32, else 80.
- Derived constant: NCYC = NROUNDS/UNROLL.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  chaining value present.
- in_ready  out  1  engine can accept a block.
- h_in  in  8*WORD_W  chaining value; word a in bits [WORD_W-1:0], h in the top word.
- abort  in  1  synchronous cancel of the current block.
- round_idx  out  7  index of the first round computed this cycle.
- k_in  in  UNROLL*WORD_W  K words; lane j holds K[round_idx+j]; combinational, same cycle.
- w_in  in  UNROLL*WORD_W  W words; lane j holds W[round_idx+j]; combinational, same cycle.
- busy  out  1  high in ROUND and FEED.
- out_valid  out  1  digest valid.
- out_ready  in  1  consumer accepts the digest.
- h_out  out  8*WORD_W  updated chaining value; same packing as h_in.

## Operation
- FSM states: IDLE, ROUND, FEED, OUT.
- IDLE:
  - in_ready=1.
  - in_valid&in_ready: latch h_in into the working registers a..h and into the saved copy H0; clear the round counter; go to ROUND.
- ROUND:
  - Compute UNROLL chained rounds combinationally from a..h using k_in/w_in lanes 0..UNROLL-1 in order.
  - Register the result; round counter += UNROLL.
  - After the cycle with round_idx == NROUNDS-UNROLL, go to FEED.
- Round function, all arithmetic mod 2^WORD_W:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + W.
  - T2 = Σ0(a) + Maj(a,b,c).
  - Next state: a'=T1+T2, b'=a, c'=b, d'=c, e'=d+T1, f'=e, g'=f, h'=g.
- Rotation amounts:
  - WORD_W=32: Σ0 = ROTR 2,13,22; Σ1 = ROTR 6,11,25.
  - WORD_W=64: Σ0 = ROTR 28,34,39; Σ1 = ROTR 14,18,41.
- FEED: h_out register = H0 + {h..a}, word-wise, mod 2^WORD_W; go to OUT.
- OUT:
  - out_valid=1; h_out held stable until out_valid&out_ready.
  - in_ready = out_ready, so a new block is accepted in the same cycle the digest is consumed (back-to-back). That transition goes to ROUND with new h_in loaded.
  - out_valid&out_ready with in_valid=0: go to IDLE.
- round_idx:
  - ROUND: round counter.
  - Other states: 0.
  - k_in/w_in are ignored outside ROUND.
- abort:
  - Any state except IDLE: next state IDLE; out_valid drops next cycle; digest discarded.
  - Abort has priority over out_ready and in_valid in the same cycle.
  - Abort in IDLE is ignored; a simultaneous in_valid is still accepted.

## Timing
- Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, round_idx=0, h_out=0, working registers and H0 = 0.
- Block accepted at edge E:
  - ROUND cycles E+1 .. E+NCYC.
  - FEED at cycle E+NCYC+1.
  - out_valid first high in cycle E+NCYC+2.
  - Latency is NCYC+2 clocks: 66 for 32-bit/UNROLL=1, 82 for 64-bit/UNROLL=1, 18 for 32-bit/UNROLL=4.
- Throughput with out_ready held high: one block per NCYC+2 cycles.
- round_idx advances by UNROLL each ROUND cycle: 0, UNROLL, 2·UNROLL, ...
- Last ROUND cycle: round_idx = NROUNDS-UNROLL.
- rst asserted mid-block: next cycle matches the reset values exactly; no digest is emitted.
- Critical path: UNROLL chained rounds. UNROLL=8 is legal but not timing-closed at the target frequency.

## Test plan
- SHA-256 "abc", WORD_W=32, UNROLL=1. Stimulus: h_in = 6a09e667…5be0cd19; bench supplies K/W from a reference model. Required: h_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with out_valid exactly 66 cycles after accept.
- SHA-512 "abc", WORD_W=64, UNROLL=2. Required: h_out = ddaf35a193617aba…a54ca49f, latency 42 cycles; round_idx sequence 0, 2, …, 78.
- Back-to-back blocks, UNROLL=4, 32-bit. Two "abc" blocks with out_ready=1 and in_valid held high. Required: second accept in the same cycle as the first digest handshake; second out_valid 18 cycles later; both digests correct.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: h_out stable, in_ready=0 throughout; digest consumed on the first out_ready=1.
- Abort at round_idx=10 with in_valid=1 in the same cycle. Required: IDLE next cycle, busy=0, no out_valid. A new block started afterwards yields the correct "abc" digest.
- rst pulse at FEED. Required: out_valid never asserts, h_out=0 next cycle, in_ready=1.
